// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/ready port
//
// Purpose: groups the fetch-side instruction memory handshake.
// Signals:
//   imem_req   - fetch request (driven by the fetch unit)
//   imem_addr  - word-aligned fetch address, stable while imem_req is high
//   imem_ready - completion; a request completes when imem_req && imem_ready
//   imem_rdata - instruction word, valid in the completion cycle
// Modports:
//   master - the fetch unit (drives req/addr)
//   slave  - the instruction memory (drives ready/rdata)

interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the IF/ID register
//
// Purpose: owns the PC, fetches over the imem port, buffers a fetched word
// while the pipeline is stalled, redirects on taken branches and inserts
// bubbles whenever no valid instruction is available.
// Ports:
//   clk             - rising-edge clock
//   reset           - asynchronous, active-low reset
//   stall           - hazard stall: hold IF/ID and PC
//   branch_taken    - taken branch/jump from ID (ignored while stalled)
//   branch_target   - redirect address, low two bits forced to zero
//   imem            - fetch_unit_if.master memory port
//   instruction_out - word presented to IF/ID
//   pc_plus4        - PC+4 of the word on instruction_out
//   IF_ID_Write     - load IF/ID this edge
//   IF_Flush        - clear IF/ID this edge (bubble)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  fetch_unit_if.master imem,
  output logic [31:0]  instruction_out,
  output logic [31:0]  pc_plus4,
  output logic         IF_ID_Write,
  output logic         IF_Flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] pc_inc;
  logic [31:0] target_aligned;
  logic        branch_go;

  assign pc_inc         = pc_q + 32'd4;
  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  assign branch_go      = branch_taken && !stall;

  // The address is always the PC; the PC only moves on a completion or
  // outside a request, so it is stable for the life of a request.
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      buf_instr_q   <= 32'h0;
      buf_pc4_q     <= 32'h0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc4_q     <= buf_pc4_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_instr_d     = buf_instr_q;
    buf_pc4_d       = buf_pc4_q;
    redirect_pc_d   = redirect_pc_q;
    imem.imem_req   = 1'b0;
    instruction_out = 32'h0;
    pc_plus4        = 32'h0;
    IF_ID_Write     = 1'b0;
    IF_Flush        = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        imem.imem_req   = 1'b1;
        instruction_out = imem.imem_rdata;
        pc_plus4        = pc_inc;
        if (branch_go) begin
          IF_Flush = 1'b1;
          if (imem.imem_ready) begin
            // Wrong-path word arrives now: drop it and redirect directly.
            pc_d = target_aligned;
          end else begin
            // The request cannot be withdrawn; finish it in DRAIN first.
            redirect_pc_d = target_aligned;
            state_d       = DRAIN;
          end
        end else if (imem.imem_ready) begin
          pc_d = pc_inc;
          if (stall) begin
            buf_instr_d = imem.imem_rdata;
            buf_pc4_d   = pc_inc;
            state_d     = HOLD;
          end else begin
            IF_ID_Write = 1'b1;
          end
        end else begin
          // Wait cycle: bubble unless IF/ID is being held by a stall.
          IF_Flush = !stall;
        end
      end

      HOLD: begin
        instruction_out = buf_instr_q;
        pc_plus4        = buf_pc4_q;
        if (!stall) begin
          state_d = FETCH;
          if (branch_taken) begin
            IF_Flush = 1'b1;
            pc_d     = target_aligned;
          end else begin
            IF_ID_Write = 1'b1;
          end
        end
      end

      DRAIN: begin
        imem.imem_req   = 1'b1;
        instruction_out = imem.imem_rdata;
        pc_plus4        = pc_inc;
        IF_Flush        = !stall;
        if (imem.imem_ready) begin
          pc_d    = redirect_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
